// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM stage; one load/store per handshake over a single-outstanding bus.
// Optional MEM_MISALIGN_CHECK_EN flags misaligned half/word accesses without touching the bus.
module mem_access_unit #(
    parameter int MEM_TIMEOUT = 255,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       pc_i,
    input  logic [ADDR_W-1:0] alu_result_i,
    input  logic [31:0]       rs2_data_i,
    input  logic [7:0]        Mem_WMask_i,
    input  logic [2:0]        Mem_RMask_i,
    input  logic [1:0]        sram_read_write_i,
    input  logic [3:0]        Gpr_Write_Addr_i,
    input  logic [2:0]        Gpr_Write_RD_i,
    input  logic              Gpr_Write_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       pc_o,
    output logic [31:0]       alu_result_o,
    output logic [31:0]       mem_rdata_o,
    output logic [3:0]        Gpr_Write_Addr_o,
    output logic [2:0]        Gpr_Write_RD_o,
    output logic              Gpr_Write_o,
    output logic              access_err_o,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_wen,
    output logic [31:0]       mem_req_wdata,
    output logic [3:0]        mem_req_wstrb,
    input  logic              mem_resp_valid,
    input  logic [31:0]       mem_resp_rdata
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_OUT} state_t;
    localparam logic [7:0] TO = 8'(MEM_TIMEOUT);

    state_t state, state_nxt, acc_st;
    logic accept, go_mem, mis, timeout, gw_q, err_q, unused_bits;
    logic [31:0] pc_q, rs2_q, rdata_q, ext;
    logic [ADDR_W-1:0] alu_q;
    logic [1:0] size_q, rw_q, off;
    logic [2:0] rm_q, grd_q;
    logic [3:0] gaddr_q, base;
    logic [7:0] cnt, byte_v;
    logic [15:0] half_v;

    assign unused_bits = ^Mem_WMask_i[7:2];
    assign accept  = in_valid && in_ready;
    assign go_mem  = sram_read_write_i == 2'b01 || sram_read_write_i == 2'b10;
    assign timeout = (cnt + 8'd1) == TO;
    assign off     = alu_q[1:0];

`ifdef MEM_MISALIGN_CHECK_EN
    assign mis = go_mem && (sram_read_write_i == 2'b01
        ? ((Mem_RMask_i == 3'b011 || Mem_RMask_i == 3'b100) && alu_result_i[0]) ||
          (Mem_RMask_i == 3'b101 && alu_result_i[1:0] != 2'b00)
        : (Mem_WMask_i[1:0] == 2'b10 && alu_result_i[0]) ||
          (Mem_WMask_i[1:0] == 2'b11 && alu_result_i[1:0] != 2'b00));
`else
    assign mis = 1'b0;
`endif

    assign acc_st = (go_mem && !mis) ? S_REQ : S_OUT;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (accept) state_nxt = acc_st;
            S_REQ:  if (mem_req_ready) state_nxt = S_WAIT;
            S_WAIT: if (mem_resp_valid || timeout) state_nxt = S_OUT;
            S_OUT:  if (out_ready) state_nxt = in_valid ? acc_st : S_IDLE;
        endcase
    end

    always_comb begin
        in_ready      = state == S_IDLE || (state == S_OUT && out_ready);
        out_valid     = state == S_OUT;
        mem_req_valid = state == S_REQ;
    end

    // Lane extraction uses the latched address; the response word is only sampled in WAIT.
    assign byte_v = 8'(mem_resp_rdata >> {off, 3'b000});
    assign half_v = off[1] ? mem_resp_rdata[31:16] : mem_resp_rdata[15:0];
    assign ext = rw_q != 2'b01 ? 32'd0 :
                 rm_q == 3'b001 ? {{24{byte_v[7]}}, byte_v} :
                 rm_q == 3'b010 ? {24'd0, byte_v} :
                 rm_q == 3'b011 ? {{16{half_v[15]}}, half_v} :
                 rm_q == 3'b100 ? {16'd0, half_v} :
                 rm_q == 3'b101 ? mem_resp_rdata : 32'd0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= '0;
            alu_q   <= '0;
            rs2_q   <= '0;
            size_q  <= '0;
            rm_q    <= '0;
            rw_q    <= '0;
            gaddr_q <= '0;
            grd_q   <= '0;
            gw_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            cnt     <= '0;
        end else begin
            cnt <= state == S_WAIT ? cnt + 8'd1 : 8'd0;
            if (accept) begin
                pc_q    <= pc_i;
                alu_q   <= alu_result_i;
                rs2_q   <= rs2_data_i;
                size_q  <= Mem_WMask_i[1:0];
                rm_q    <= Mem_RMask_i;
                rw_q    <= sram_read_write_i;
                gaddr_q <= Gpr_Write_Addr_i;
                grd_q   <= Gpr_Write_RD_i;
                gw_q    <= Gpr_Write_i;
                err_q   <= mis;
                rdata_q <= '0;
            end else if (state == S_WAIT && mem_resp_valid) begin
                rdata_q <= ext;
            end else if (state == S_WAIT && timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    assign pc_o             = pc_q;
    assign alu_result_o     = 32'(alu_q);
    assign mem_rdata_o      = rdata_q;
    assign Gpr_Write_Addr_o = gaddr_q;
    assign Gpr_Write_RD_o   = grd_q;
    assign Gpr_Write_o      = gw_q && !err_q;
    assign access_err_o     = err_q;

    // Oversized strobes simply fall off the top lane (e.g. half at offset 3 -> 1000).
    assign base = size_q == 2'b01 ? 4'b0001 : size_q == 2'b10 ? 4'b0011 :
                  size_q == 2'b11 ? 4'b1111 : 4'b0000;
    assign mem_req_addr  = {alu_q[ADDR_W-1:2], 2'b00};
    assign mem_req_wen   = state == S_REQ && rw_q == 2'b10;
    assign mem_req_wstrb = mem_req_wen ? base << off : 4'b0000;
    assign mem_req_wdata = mem_req_wen ? rs2_q << {off, 3'b000} : 32'd0;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for mem_access_unit (MEM_TIMEOUT=4).
module tb_mem_access_unit;
    logic clk = 1'b0;
    logic reset, in_valid, in_ready, Gpr_Write_i, out_valid, out_ready;
    logic [31:0] pc_i, alu_result_i, rs2_data_i, pc_o, alu_result_o, mem_rdata_o;
    logic [7:0] Mem_WMask_i;
    logic [2:0] Mem_RMask_i, Gpr_Write_RD_i, Gpr_Write_RD_o;
    logic [1:0] sram_read_write_i;
    logic [3:0] Gpr_Write_Addr_i, Gpr_Write_Addr_o, mem_req_wstrb;
    logic Gpr_Write_o, access_err_o, mem_req_valid, mem_req_ready, mem_req_wen, mem_resp_valid;
    logic [31:0] mem_req_addr, mem_req_wdata, mem_resp_rdata;
    int errors = 0;
    int checks = 0;
    int n;

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_TIMEOUT(4), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .pc_i(pc_i), .alu_result_i(alu_result_i), .rs2_data_i(rs2_data_i),
        .Mem_WMask_i(Mem_WMask_i), .Mem_RMask_i(Mem_RMask_i),
        .sram_read_write_i(sram_read_write_i), .Gpr_Write_Addr_i(Gpr_Write_Addr_i),
        .Gpr_Write_RD_i(Gpr_Write_RD_i), .Gpr_Write_i(Gpr_Write_i),
        .out_valid(out_valid), .out_ready(out_ready), .pc_o(pc_o),
        .alu_result_o(alu_result_o), .mem_rdata_o(mem_rdata_o),
        .Gpr_Write_Addr_o(Gpr_Write_Addr_o), .Gpr_Write_RD_o(Gpr_Write_RD_o),
        .Gpr_Write_o(Gpr_Write_o), .access_err_o(access_err_o),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
        .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic send(input logic [1:0] rw, input logic [7:0] wm, input logic [2:0] rm,
                        input logic [31:0] addr, input logic [31:0] data, input logic gw);
        in_valid = 1'b1; sram_read_write_i = rw; Mem_WMask_i = wm; Mem_RMask_i = rm;
        alu_result_i = addr; rs2_data_i = data; pc_i = 32'h4000_0000 | addr;
        Gpr_Write_Addr_i = 4'd7; Gpr_Write_RD_i = 3'd2; Gpr_Write_i = gw;
        step();
        in_valid = 1'b0;
    endtask

    task automatic bus(input logic [31:0] rd);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_rdata = rd;
        step();
        mem_resp_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; pc_i = '0; alu_result_i = '0;
        rs2_data_i = '0; Mem_WMask_i = '0; Mem_RMask_i = '0; sram_read_write_i = '0;
        Gpr_Write_Addr_i = '0; Gpr_Write_RD_i = '0; Gpr_Write_i = 1'b0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_alu_o", alu_result_o, 32'd0);
        step(); step();
        reset = 1'b1;
        step();

        // non-memory passthrough
        send(2'b00, 8'h0, 3'b000, 32'h1234, 32'h0, 1'b1);
        chk("alu_valid", 32'(out_valid), 32'd1);
        chk("alu_result", alu_result_o, 32'h1234);
        chk("alu_pc", pc_o, 32'h4000_1234);
        chk("alu_rdata", mem_rdata_o, 32'd0);
        chk("alu_noreq", 32'(mem_req_valid), 32'd0);
        chk("alu_gw", 32'(Gpr_Write_o), 32'd1);
        chk("alu_gaddr", 32'(Gpr_Write_Addr_o), 32'd7);
        step();
        chk("alu_idle", 32'(out_valid), 32'd0);

        // lb then lbu back-to-back
        send(2'b01, 8'h0, 3'b001, 32'h8000_0003, 32'h0, 1'b1);
        chk("lb_req_valid", 32'(mem_req_valid), 32'd1);
        chk("lb_req_addr", mem_req_addr, 32'h8000_0000);
        chk("lb_req_wen", 32'(mem_req_wen), 32'd0);
        chk("lb_req_wstrb", 32'(mem_req_wstrb), 32'd0);
        bus(32'h80FF_0000);
        chk("lb_valid", 32'(out_valid), 32'd1);
        chk("lb_rdata", mem_rdata_o, 32'hFFFF_FF80);
        chk("lb_err", 32'(access_err_o), 32'd0);
        chk("lb_gw", 32'(Gpr_Write_o), 32'd1);
        chk("lb_in_ready", 32'(in_ready), 32'd1);
        send(2'b01, 8'h0, 3'b010, 32'h8000_0003, 32'h0, 1'b1);
        chk("lbu_req_valid", 32'(mem_req_valid), 32'd1);
        bus(32'h80FF_0000);
        chk("lbu_rdata", mem_rdata_o, 32'h0000_0080);
        send(2'b01, 8'h0, 3'b011, 32'h0000_0002, 32'h0, 1'b1);
        bus(32'h80FF_1234);
        chk("lh_rdata", mem_rdata_o, 32'hFFFF_80FF);
        step();

        // sh with a stall and a stray response
        send(2'b10, 8'b1111_1110, 3'b000, 32'h2, 32'h0000_BEEF, 1'b0);
        chk("sh_req_valid", 32'(mem_req_valid), 32'd1);
        chk("sh_req_addr", mem_req_addr, 32'h0);
        chk("sh_wstrb", 32'(mem_req_wstrb), 32'hC);
        chk("sh_wdata", mem_req_wdata, 32'hBEEF_0000);
        chk("sh_wen", 32'(mem_req_wen), 32'd1);
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'hDEAD_DEAD;
        step();
        mem_resp_valid = 1'b0;
        chk("sh_hold_valid", 32'(mem_req_valid), 32'd1);
        chk("sh_hold_wdata", mem_req_wdata, 32'hBEEF_0000);
        chk("sh_hold_out", 32'(out_valid), 32'd0);
        bus(32'h1111_1111);
        chk("sh_valid", 32'(out_valid), 32'd1);
        chk("sh_rdata", mem_rdata_o, 32'd0);
        step();

        // sh at offset 3: strobe truncated
        send(2'b10, 8'h02, 3'b000, 32'h7, 32'h0000_BEEF, 1'b0);
        chk("sh3_wstrb", 32'(mem_req_wstrb), 32'h8);
        chk("sh3_wdata", mem_req_wdata, 32'hEF00_0000);
        bus(32'h0);
        step();

        // timeout: no response for 4 WAIT cycles
        send(2'b01, 8'h0, 3'b101, 32'h10, 32'h0, 1'b1);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            n++;
            step();
        end
        chk("to_wait_cycles", 32'(n), 32'd4);
        chk("to_err", 32'(access_err_o), 32'd1);
        chk("to_gw", 32'(Gpr_Write_o), 32'd0);
        chk("to_rdata", mem_rdata_o, 32'd0);
        step();

        // response in the timeout cycle wins
        send(2'b01, 8'h0, 3'b101, 32'h10, 32'h0, 1'b1);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        step(); step(); step();
        chk("race_still_wait", 32'(out_valid), 32'd0);
        mem_resp_valid = 1'b1; mem_resp_rdata = 32'hCAFE_BABE;
        step();
        mem_resp_valid = 1'b0;
        chk("race_valid", 32'(out_valid), 32'd1);
        chk("race_err", 32'(access_err_o), 32'd0);
        chk("race_rdata", mem_rdata_o, 32'hCAFE_BABE);
        chk("race_gw", 32'(Gpr_Write_o), 32'd1);
        step();

        // backpressure in OUT, then zero-bubble replacement
        out_ready = 1'b0;
        send(2'b00, 8'h0, 3'b000, 32'hAAAA, 32'h0, 1'b1);
        in_valid = 1'b1; alu_result_i = 32'hBBBB; pc_i = 32'h4000_BBBB;
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_alu_hold", alu_result_o, 32'hAAAA);
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        chk("bp_next_valid", 32'(out_valid), 32'd1);
        chk("bp_next_alu", alu_result_o, 32'hBBBB);
        step();
        chk("bp_idle", 32'(out_valid), 32'd0);

        // misaligned word store at 0x6
        send(2'b10, 8'h03, 3'b000, 32'h6, 32'h1234_5678, 1'b1);
`ifdef MEM_MISALIGN_CHECK_EN
        chk("mis_valid", 32'(out_valid), 32'd1);
        chk("mis_err", 32'(access_err_o), 32'd1);
        chk("mis_gw", 32'(Gpr_Write_o), 32'd0);
        chk("mis_noreq", 32'(mem_req_valid), 32'd0);
        step();
        send(2'b01, 8'h0, 3'b101, 32'h6, 32'h0, 1'b1);
        chk("misl_err", 32'(access_err_o), 32'd1);
        chk("misl_noreq", 32'(mem_req_valid), 32'd0);
        chk("misl_rdata", mem_rdata_o, 32'd0);
        step();
`else
        chk("mis_req_valid", 32'(mem_req_valid), 32'd1);
        chk("mis_addr", mem_req_addr, 32'h4);
        chk("mis_wstrb", 32'(mem_req_wstrb), 32'hC);
        chk("mis_wdata", mem_req_wdata, 32'h5678_0000);
        bus(32'h0);
        chk("mis_err", 32'(access_err_o), 32'd0);
        step();
`endif

        // reset mid-transaction withdraws the request
        send(2'b01, 8'h0, 3'b101, 32'h20, 32'h0, 1'b1);
        chk("mid_req", 32'(mem_req_valid), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_rst_req", 32'(mem_req_valid), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        step();
        reset = 1'b1;
        step();
        chk("mid_idle", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
